seu_ram_scrubber: RTL and testbench
===================================

# seu_ram_scrubber

Write-side and check-side companion to the SEU test memory. Fills a 16 x 8 memory with a known address-derived pattern, then on command scans it back through the memory's registered read port, counts single-event-upset mismatches, records the last failing address and rewrites corrupted words. Sits between the SEU test controller (start/clear strobes, status readout) and the SEU test RAM.

## Interface

Parameters:
- ADDR_W, 4, memory address width; depth = 2^ADDR_W.
- DATA_W, 8, memory word width; must be >= ADDR_W.
- CNT_W, 16, error counter width.
- PATTERN_XOR, 8'h00, expected word = zero-extended address XOR PATTERN_XOR.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- start_fill  in  1  one-cycle strobe: write the pattern to all addresses.
- start_scan  in  1  one-cycle strobe: read, compare and repair all addresses.
- clear_err  in  1  one-cycle strobe: clear err_cnt, err_flag, last_err_addr.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_re.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a fill or scan completes.
- err_cnt  out  CNT_W  saturating count of mismatching words.
- err_flag  out  1  sticky: at least one mismatch since the last clear/reset.
- last_err_addr  out  ADDR_W  address of the most recent mismatch.

## Operation

- States: IDLE, FILL, SCAN_RD, SCAN_CMP, FIX, DONE.
- All outputs are registered. Reset value of every output is 0. Reset also clears the internal address counter and returns the FSM to IDLE.
- IDLE: start_fill -> FILL with addr = 0. Otherwise start_scan -> SCAN_RD with addr = 0. start_fill wins when both strobes arrive together. Strobes outside IDLE are ignored.
- FILL: one write per cycle.
  - mem_we = 1, mem_addr = addr, mem_wdata = expected(addr).
  - At the last address (2^ADDR_W - 1) go to DONE; otherwise addr increments.
- SCAN_RD: mem_re = 1, mem_addr = addr; go to SCAN_CMP.
- SCAN_CMP: compare mem_rdata with expected(addr).
  - Match: the last address goes to DONE; otherwise addr increments and the FSM goes to SCAN_RD.
  - Mismatch: err_cnt increments (holds at all-ones), err_flag = 1, last_err_addr = addr; go to FIX.
- FIX: mem_we = 1, mem_addr = addr, mem_wdata = expected(addr). Then DONE if this is the last address, else addr increments and the FSM goes to SCAN_RD.
- DONE: done = 1 for one cycle; return to IDLE.
- Outside FILL/FIX, mem_we = 0. Outside SCAN_RD, mem_re = 0. mem_addr and mem_wdata hold their last values.
- clear_err is accepted in any state. If it coincides with a mismatch increment, clear wins: the result is err_cnt = 0, err_flag = 0, last_err_addr = 0.
- Reset mid-operation aborts immediately; memory contents are left as partially written.
- Width rule: expected(addr) = {zeros, addr} ^ PATTERN_XOR, truncated to DATA_W.

## Timing

- Fill: strobe sampled at edge 0. mem_we is high on cycles 1..16 with addresses 0..15. done is high on cycle 17. busy is high on cycles 1..17.
- Clean scan: per-word cost is 2 cycles (SCAN_RD, SCAN_CMP). mem_re for address 0 is high on cycle 1; its data is compared on cycle 2. done is on cycle 33.
- Each mismatch adds exactly 1 cycle (FIX).
- The repair write issues on the cycle after detection. err_cnt/err_flag update on the same edge that enters FIX.
- A new start is accepted on the first IDLE cycle after done.

## Test plan

- Fill with PATTERN_XOR = 0, then inspect memory -> word n = n for n = 0..15; done on cycle 17; busy deasserts with done.
- Fill, then clean scan -> done on cycle 33; err_cnt = 0; err_flag = 0; no mem_we during the scan.
- Fill, force memory[5] = 8'hA5 and memory[15] = 8'h00, then scan -> err_cnt = 2, last_err_addr = 15, err_flag = 1; FIX writes 8'h05 and 8'h0F; done on cycle 35; a rescan gives err_cnt still 2 with no new FIX.
- start_fill and start_scan asserted together -> fill performed and no mem_re. start_scan asserted during the fill -> ignored.
- With CNT_W = 2, corrupt all 16 words and scan -> err_cnt saturates at 3. Pulse clear_err on a mismatch cycle -> err_cnt = 0 and err_flag = 0.
- Assert rst low at scan cycle 10 -> next edge: all outputs 0, FSM in IDLE. A new scan restarts from address 0.

Source files
------------

// File: rtl/seu_ram_scrubber.sv
// Fills a 2^ADDR_W x DATA_W test memory with an address-derived pattern. On command it
// scans the memory back, counts mismatching words (SEUs) and rewrites each corrupted word.
// Latency: a fill takes 2^ADDR_W+1 cycles after the strobe. A scan takes 2*2^ADDR_W+1
// cycles, plus 1 cycle per repaired word.
// Backpressure: none. Strobes that arrive outside IDLE are dropped, and clear_err is accepted in any state.
//
// Ports:
//   clk, rst          single clock and synchronous active-low reset
//   start_fill        strobe: write the pattern to every address
//   start_scan        strobe: read, compare and repair every address
//   clear_err         strobe: zero err_cnt, err_flag and last_err_addr
//   mem_we/re/addr/wdata, mem_rdata
//                     memory port. Read data returns the cycle after mem_re.
//   busy, done        status. done pulses for one cycle at completion.
//   err_cnt, err_flag, last_err_addr
//                     error status. The counter saturates and the flag is sticky.
module seu_ram_scrubber #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  parameter logic [DATA_W-1:0] PATTERN_XOR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_fill,
  input  logic              start_scan,
  input  logic              clear_err,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_flag,
  output logic [ADDR_W-1:0] last_err_addr
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FILL     = 3'd1,
    SCAN_RD  = 3'd2,
    SCAN_CMP = 3'd3,
    FIX      = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;

  // Next values of the registered outputs
  logic              mem_we_nxt, mem_re_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic              busy_nxt, done_nxt;
  logic [CNT_W-1:0]  err_cnt_nxt;
  logic              err_flag_nxt;
  logic [ADDR_W-1:0] last_err_addr_nxt;
  logic              mismatch;

  // Expected word: the address is zero-extended to the word width, then XORed with the pattern.
  function automatic logic [DATA_W-1:0] expected(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ext;
    ext = '0;
    ext[ADDR_W-1:0] = a;
    return ext ^ PATTERN_XOR;
  endfunction

  // mem_rdata carries the word requested in the previous SCAN_RD cycle, at the same addr.
  assign mismatch = (state == SCAN_CMP) && (mem_rdata != expected(addr));

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    unique case (state)
      IDLE: begin
        if (start_fill) begin
          state_nxt = FILL;
          addr_nxt  = '0;
        end else if (start_scan) begin
          state_nxt = SCAN_RD;
          addr_nxt  = '0;
        end
      end
      FILL: begin
        if (addr == LAST_ADDR) state_nxt = DONE;
        else                   addr_nxt  = addr + ADDR_W'(1);
      end
      SCAN_RD: state_nxt = SCAN_CMP;
      SCAN_CMP: begin
        if (mismatch) begin
          state_nxt = FIX;
        end else if (addr == LAST_ADDR) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SCAN_RD;
          addr_nxt  = addr + ADDR_W'(1);
        end
      end
      FIX: begin
        if (addr == LAST_ADDR) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SCAN_RD;
          addr_nxt  = addr + ADDR_W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The outputs are decoded from the next state. This lets the registered strobes line up
  // with the state that the FSM occupies during the same cycle.
  always_comb begin
    mem_we_nxt    = (state_nxt == FILL) || (state_nxt == FIX);
    mem_re_nxt    = (state_nxt == SCAN_RD);
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if (mem_we_nxt || mem_re_nxt) mem_addr_nxt  = addr_nxt;
    if (mem_we_nxt)               mem_wdata_nxt = expected(addr_nxt);
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // Error bookkeeping. If a clear and a mismatch arrive together, the clear takes priority.
  always_comb begin
    err_cnt_nxt       = err_cnt;
    err_flag_nxt      = err_flag;
    last_err_addr_nxt = last_err_addr;
    if (clear_err) begin
      err_cnt_nxt       = '0;
      err_flag_nxt      = 1'b0;
      last_err_addr_nxt = '0;
    end else if (mismatch) begin
      if (err_cnt != CNT_MAX) err_cnt_nxt = err_cnt + CNT_W'(1);
      err_flag_nxt      = 1'b1;
      last_err_addr_nxt = addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      addr          <= '0;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_cnt       <= '0;
      err_flag      <= 1'b0;
      last_err_addr <= '0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      mem_we        <= mem_we_nxt;
      mem_re        <= mem_re_nxt;
      mem_addr      <= mem_addr_nxt;
      mem_wdata     <= mem_wdata_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
      err_cnt       <= err_cnt_nxt;
      err_flag      <= err_flag_nxt;
      last_err_addr <= last_err_addr_nxt;
    end
  end

endmodule

// File: tb/tb_seu_ram_scrubber.sv
// Directed bench for seu_ram_scrubber. It models a 16 x 8 RAM with a registered read port.
// The bench also provides a back-door write port, which is used to plant upsets.
module tb_seu_ram_scrubber;

  logic       clk;
  logic       rst;
  logic       start_fill, start_scan, clear_err;
  logic       mem_we, mem_re;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy, done;
  logic [1:0] err_cnt;
  logic       err_flag;
  logic [3:0] last_err_addr;

  seu_ram_scrubber #(
    .ADDR_W(4), .DATA_W(8), .CNT_W(2), .PATTERN_XOR(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .start_fill(start_fill), .start_scan(start_scan), .clear_err(clear_err),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done),
    .err_cnt(err_cnt), .err_flag(err_flag), .last_err_addr(last_err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [7:0] mem [16];
  logic       poke_en;
  logic [3:0] poke_addr;
  logic [7:0] poke_data;

  always @(posedge clk) begin
    if (mem_we)  mem[mem_addr]  <= mem_wdata;
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_re)  mem_rdata      <= mem[mem_addr];
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Per-operation observations
  int         cyc, done_cyc, we_cnt, re_cnt, busy_lo;
  logic [3:0] wa [32];
  logic [7:0] wd [32];
  int         wc [32];
  logic [3:0] ra [32];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    tick();
    poke_en   = 1'b0;
  endtask

  // The strobes are sampled at edge 0. Cycle k is the interval that follows edge k-1.
  // The task can raise start_scan during cycle scan_at and clear_err during cycle clr_at.
  task automatic run(input logic f, input logic s, input int scan_at, input int clr_at);
    start_fill = f;
    start_scan = s;
    tick();
    start_fill = 1'b0;
    start_scan = 1'b0;
    cyc = 1; done_cyc = 0; we_cnt = 0; re_cnt = 0; busy_lo = 0;
    while (done_cyc == 0 && cyc < 120) begin
      if (mem_we) begin
        if (we_cnt < 32) begin
          wa[we_cnt] = mem_addr;
          wd[we_cnt] = mem_wdata;
          wc[we_cnt] = cyc;
        end
        we_cnt++;
      end
      if (mem_re) begin
        if (re_cnt < 32) ra[re_cnt] = mem_addr;
        re_cnt++;
      end
      if (!busy) busy_lo++;
      if (done) begin
        done_cyc = cyc;
      end else begin
        start_scan = (cyc == scan_at);
        clear_err  = (cyc == clr_at);
        tick();
        cyc++;
      end
    end
    start_scan = 1'b0;
    clear_err  = 1'b0;
    tick();
    check("post_done_low", done, 0);
    check("post_busy_low", busy, 0);
    check("busy_during_op", busy_lo, 0);
  endtask

  initial begin
    rst = 1'b0; start_fill = 1'b0; start_scan = 1'b0; clear_err = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;

    // Reset state
    repeat (3) tick();
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_last_err", last_err_addr, 0);
    rst = 1'b1;
    tick();

    // Fill: writes 0..15 on cycles 1..16, and done arrives on cycle 17
    run(1'b1, 1'b0, -1, -1);
    check("fill_done_cyc", done_cyc, 17);
    check("fill_we_cnt", we_cnt, 16);
    check("fill_re_cnt", re_cnt, 0);
    check("fill_first_we_cyc", wc[0], 1);
    check("fill_last_addr", wa[15], 15);
    for (int i = 0; i < 16; i++) check("fill_word", mem[i], i);

    // Clean scan
    run(1'b0, 1'b1, -1, -1);
    check("scan_done_cyc", done_cyc, 33);
    check("scan_re_cnt", re_cnt, 16);
    check("scan_first_re", ra[0], 0);
    check("scan_we_cnt", we_cnt, 0);
    check("scan_err_cnt", err_cnt, 0);
    check("scan_err_flag", err_flag, 0);

    // Two planted upsets. The repair of address 5 lands on cycle 13 and address 15 on cycle 34.
    poke(4'd5, 8'hA5);
    poke(4'd15, 8'h00);
    run(1'b0, 1'b1, -1, -1);
    check("seu_done_cyc", done_cyc, 35);
    check("seu_err_cnt", err_cnt, 2);
    check("seu_err_flag", err_flag, 1);
    check("seu_last_err", last_err_addr, 15);
    check("seu_we_cnt", we_cnt, 2);
    check("seu_fix0_addr", wa[0], 5);
    check("seu_fix0_data", wd[0], 8'h05);
    check("seu_fix0_cyc", wc[0], 13);
    check("seu_fix1_addr", wa[1], 15);
    check("seu_fix1_data", wd[1], 8'h0F);
    check("seu_fix1_cyc", wc[1], 34);
    check("seu_mem5", mem[5], 8'h05);
    check("seu_mem15", mem[15], 8'h0F);

    // Rescan after repair
    run(1'b0, 1'b1, -1, -1);
    check("rescan_done_cyc", done_cyc, 33);
    check("rescan_err_cnt", err_cnt, 2);
    check("rescan_we_cnt", we_cnt, 0);

    // Idle clear
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("clr_err_cnt", err_cnt, 0);
    check("clr_err_flag", err_flag, 0);
    check("clr_last_err", last_err_addr, 0);

    // Both strobes together: fill wins
    run(1'b1, 1'b1, -1, -1);
    check("both_done_cyc", done_cyc, 17);
    check("both_we_cnt", we_cnt, 16);
    check("both_re_cnt", re_cnt, 0);

    // start_scan during a fill is ignored
    run(1'b1, 1'b0, 5, -1);
    check("midscan_done_cyc", done_cyc, 17);
    check("midscan_re_cnt", re_cnt, 0);
    tick();
    check("midscan_no_late_busy", busy, 0);

    // Every word corrupted: the 2-bit counter saturates at 3
    for (int i = 0; i < 16; i++) poke(4'(i), 8'(i) ^ 8'hFF);
    run(1'b0, 1'b1, -1, -1);
    check("sat_done_cyc", done_cyc, 49);
    check("sat_err_cnt", err_cnt, 3);
    check("sat_err_flag", err_flag, 1);
    check("sat_last_err", last_err_addr, 15);
    check("sat_we_cnt", we_cnt, 16);
    for (int i = 0; i < 16; i++) check("sat_repaired", mem[i], i);

    // Reset during scan cycle 10
    start_scan = 1'b1;
    tick();
    start_scan = 1'b0;
    repeat (9) tick();
    check("prerst_busy", busy, 1);
    check("prerst_addr", mem_addr, 4);
    rst = 1'b0;
    tick();
    check("midrst_mem_we", mem_we, 0);
    check("midrst_mem_re", mem_re, 0);
    check("midrst_mem_addr", mem_addr, 0);
    check("midrst_mem_wdata", mem_wdata, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err_cnt", err_cnt, 0);
    check("midrst_err_flag", err_flag, 0);
    check("midrst_last_err", last_err_addr, 0);
    rst = 1'b1;
    run(1'b0, 1'b1, -1, -1);
    check("rst_rescan_done_cyc", done_cyc, 33);
    check("rst_rescan_first_re", ra[0], 0);
    check("rst_rescan_re_cnt", re_cnt, 16);

    // Clear coincides with the mismatch at address 9, which is compared on cycle 21
    poke(4'd2, 8'h77);
    poke(4'd9, 8'h00);
    run(1'b0, 1'b1, -1, 21);
    check("clrhit_done_cyc", done_cyc, 35);
    check("clrhit_we_cnt", we_cnt, 2);
    check("clrhit_err_cnt", err_cnt, 0);
    check("clrhit_err_flag", err_flag, 0);
    check("clrhit_last_err", last_err_addr, 0);
    check("clrhit_mem9", mem[9], 8'h09);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
